// File: rtl/m_ext_seq.sv
// Sequential RV M-extension unit: shared shift/add-subtract datapath,
// XLEN iterations per op, valid/ready on both sides.
module m_ext_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  dv_q, dv_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;

    logic            is_div, sgn_a_en, sgn_b_en, neg_a, neg_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    assign is_div   = funct3[2];
    assign sgn_a_en = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign sgn_b_en = is_div ? ~funct3[0] : ~funct3[1];
    assign neg_a    = sgn_a_en & a[XLEN-1];
    assign neg_b    = sgn_b_en & b[XLEN-1];
    assign mag_a    = neg_a ? -a : a;
    assign mag_b    = neg_b ? -b : b;
    assign div_zero = is_div & (b == '0);
    assign div_ovf  = is_div & ~funct3[0] & (a == SMIN) & (b == '1);

    // One adder serves both: mul adds the multiplicand, div subtracts the divisor.
    logic [XLEN:0]     add_x, add_y, sum;
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN-1:0]   hi_n;

    assign add_x  = f3_q[2] ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    assign add_y  = f3_q[2] ? ~{1'b0, dv_q}
                            : (lo_q[0] ? {1'b0, dv_q} : '0);
    assign sum    = add_x + add_y + {{XLEN{1'b0}}, f3_q[2]};
    assign prod_n = -{hi_q, lo_q};
    assign hi_n   = -hi_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dv_d     = dv_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    f3_d     = funct3;
                    cnt_d    = '0;
                    neg_lo_d = neg_a ^ neg_b;
                    neg_hi_d = is_div ? neg_a : (neg_a ^ neg_b);
                    hi_d     = '0;
                    if (div_zero) begin
                        hi_d    = a;
                        lo_d    = '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        lo_d    = a;
                        state_d = DONE;
                    end else if (is_div) begin
                        lo_d    = mag_a;
                        dv_d    = mag_b;
                        state_d = CALC;
                    end else begin
                        lo_d    = mag_b;
                        dv_d    = mag_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (f3_q[2]) begin
                    hi_d = sum[XLEN] ? add_x[XLEN-1:0] : sum[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], ~sum[XLEN]};
                end else begin
                    hi_d = sum[XLEN:1];
                    lo_d = {sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (!f3_q[2]) begin
                    if (neg_lo_q) {hi_d, lo_d} = prod_n;
                end else begin
                    if (neg_lo_q) lo_d = prod_n[XLEN-1:0];
                    if (neg_hi_q) hi_d = hi_n;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dv_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dv_q     <= dv_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    // Partial sums stay internal; outputs only show a finished result.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign hi        = out_valid ? hi_q : '0;
    assign lo        = out_valid ? lo_q : '0;
    assign res       = (f3_q == 3'b000 || f3_q[2:1] == 2'b10) ? lo : hi;

endmodule

// File: tb/tb_m_ext_seq.sv
// Randomized self-checking bench for m_ext_seq against an arithmetic
// reference model.
module tb_m_ext_seq;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] res, hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    m_ext_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .a(a), .b(b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [2:0] f,
                                   input logic [31:0] av, bv,
                                   output logic [31:0] eh, el, er,
                                   output bit sp);
        logic [63:0] p;
        longint sa, sb;
        sp = 0;
        eh = '0;
        el = '0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (f)
            3'd0, 3'd1: p = 64'(sa * sb);
            3'd2:       p = 64'(sa * longint'({32'b0, bv}));
            3'd3:       p = {32'b0, av} * {32'b0, bv};
            default:    p = '0;
        endcase
        if (!f[2]) begin
            eh = p[63:32];
            el = p[31:0];
        end else if (bv == 0) begin
            el = '1; eh = av; sp = 1;
        end else if (!f[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            el = av; eh = '0; sp = 1;
        end else if (!f[0]) begin
            el = 32'(sa / sb);
            eh = 32'(sa % sb);
        end else begin
            el = av / bv;
            eh = av % bv;
        end
        case (f)
            3'd0, 3'd4, 3'd5: er = el;
            default:          er = eh;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] av, bv,
                          input int hold, input logic fl);
        logic [31:0] eh, el, er;
        bit sp;
        int cyc;
        ref_op(f, av, bv, eh, el, er, sp);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; funct3 = f; a = av; b = bv; flush = fl;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        a = $urandom; b = $urandom; funct3 = 3'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 3 * XLEN) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), sp ? 64'd1 : 64'(XLEN + 2));
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("res", res, er);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_res", res, er);
            chk("hold_rdy", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("ack_valid", out_valid, 0);
        chk("ack_rdy", in_ready, 1);
    endtask

    task automatic start_op(input logic [2:0] f, input logic [31:0] av, bv);
        @(negedge clk);
        in_valid = 1; funct3 = f; a = av; b = bv;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    initial begin
        int seen, cyc;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_res", res, 0);
        chk("rst_hilo", {hi, lo}, 0);
        @(negedge clk);
        rst = 0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'd7, 32'd100, 32'd7, 0, 0);
        run_op(3'd5, 32'd5, 32'd0, 0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 10, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1);

        // flush mid-CALC: no result may ever appear
        start_op(3'd0, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        chk("calc_rdy", in_ready, 0);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_rdy", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("flush_nopulse", 64'(seen), 0);

        // flush wins over out_ready in DONE
        start_op(3'd5, 32'd5, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_reached", out_valid, 1);
        flush = 1; out_ready = 1;
        @(posedge clk); #1;
        flush = 0; out_ready = 0;
        chk("done_flush_valid", out_valid, 0);
        chk("done_flush_rdy", in_ready, 1);

        // async reset mid-CALC
        start_op(3'd0, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_rdy", in_ready, 1);
        chk("arst_res", res, 0);
        chk("arst_hilo", {hi, lo}, 0);
        @(negedge clk);
        rst = 0;
        run_op(3'd0, 32'd3, 32'd4, 0, 0);

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom), pick(), pick(),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_ext_seq.md
Name: m_ext_seq

Overview:
- Parametrised, multi-cycle successor to the combinational M-extension unit.
- Executes all eight RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over XLEN iterations using one shared shift/add-subtract datapath.
- Uses valid/ready handshakes on both sides.
- Sits in the execute stage beside the ALU. The pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and even.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- flush  in  1  abort in-flight op (pipeline kill).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- res  out  XLEN  architectural result selected by the latched funct3.
- hi  out  XLEN  mul: product[2XLEN-1:XLEN]; div: remainder.
- lo  out  XLEN  mul: product[XLEN-1:0]; div: quotient.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, res/hi/lo=0, counter=0.
- States:
  - IDLE: in_ready=1. An accept is in_valid&in_ready. On accept, latch funct3 and the operand magnitudes; record the result negation flags; go to CALC.
  - Special cases on accept go straight to DONE instead (see below).
  - CALC: one iteration per cycle for exactly XLEN cycles.
    - Mul: shift-add of the unsigned magnitudes.
    - Div: restoring shift-subtract.
  - FIX: one cycle. Apply two's-complement negation to the result if its flag is set:
    - MUL/MULH: sign(a)^sign(b) on the 2XLEN product.
    - MULHSU: sign(a) only; b is treated unsigned.
    - DIV: quotient negated by sign(a)^sign(b).
    - REM: remainder takes sign(a).
    - Unsigned ops: no correction.
  - DONE: out_valid=1; res/hi/lo held stable. On out_ready go to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Latency: accept at edge k; out_valid=1 after edge k+XLEN+2.
- Special cases (decided at accept, bypass CALC/FIX, out_valid after edge k+1):
  - Divide by zero (b==0, any div/rem op): quotient = all ones; remainder = a.
  - Signed overflow (DIV/REM with a = 1<<(XLEN-1) and b = all ones): quotient = a; remainder = 0.
- res selection:
  - MUL: lo.
  - MULH/MULHSU/MULHU: hi.
  - DIV/DIVU: lo.
  - REM/REMU: hi.
- in_ready=0 in CALC, FIX and DONE. Inputs are ignored while in_ready=0.
- Operand inputs need not stay stable after accept.
- flush: in any non-IDLE state, next state is IDLE and out_valid=0 the next cycle. No result is produced.
  - Flush is ignored in IDLE: an accept concurrent with flush is still accepted.
  - flush in DONE together with out_ready: the flush wins and the result is dropped.
- Counter terminal value XLEN-1 triggers CALC→FIX. The counter does not wrap into a second pass.
- Reset mid-CALC: immediate return to the reset values. No partial result is visible.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3), XLEN=32 -> after 34 cycles: lo=0xFFFFFFEB, hi=0xFFFFFFFF, res=0xFFFFFFEB.
- MULHU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, res=0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). REMU a=100, b=7 -> res=2, lo=14.
- DIVU a=5, b=0 -> out_valid one cycle after accept, lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, one-cycle latency.
- Backpressure: out_ready low 10 cycles -> out_valid and res stable throughout, in_ready=0. After out_ready, in_ready=1 the next cycle and a back-to-back op completes correctly.
- flush asserted at CALC cycle 5 -> IDLE next cycle, no out_valid pulse. rst asserted asynchronously mid-CALC -> outputs zero immediately; a fresh MUL 3×4 then yields lo=12.
